// File: rtl/multiword_add_seq_pkg.sv
// Shared types and defaults for the multi-word add/subtract sequencer.
// The index-width helper sizes the word counter from WORDS.
package multiword_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned DEF_W     = 32;
    localparam int unsigned DEF_WORDS = 4;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Operand request and result handshake bundle for multiword_add_seq.
// The slave side is the sequencer; the master side is the producer/consumer.
interface multiword_add_seq_if
    import multiword_add_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned WORDS = DEF_WORDS
);
    logic                 in_valid;
    logic                 in_ready;
    logic [W*WORDS-1:0]   in_a;
    logic [W*WORDS-1:0]   in_b;
    logic                 in_sub;
    logic                 in_cin;
    logic                 out_valid;
    logic                 out_ready;
    logic [W*WORDS-1:0]   out_sum;
    logic                 out_cout;
    logic                 out_of;
    logic                 busy;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_of, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_of, busy
    );

endinterface

// File: rtl/multiword_add_seq_adder_word.sv
// Combinational W-bit word adder with carry out and signed overflow.
// Overflow is the carry into the MSB xor the carry out of the MSB.
module adder_word
    import multiword_add_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         of
);
    logic [W:0] w_full;
    logic       w_msb_cin;

    assign w_full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum       = w_full[W-1:0];
    assign cout      = w_full[W];
    assign w_msb_cin = a[W-1] ^ b[W-1] ^ w_full[W-1];
    assign of        = w_msb_cin ^ w_full[W];

endmodule

// File: rtl/multiword_add_seq.sv
// Wide add/subtract built by stepping one shared W-bit adder over WORDS words,
// least-significant word first, with the carry held in a register between words.
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned WORDS = DEF_WORDS
) (
    input  logic                clk,
    input  logic                rst,
    multiword_add_seq_if.slave  bus
);
    localparam int unsigned IW = clog2(WORDS);

    state_t               r_state;
    logic [W*WORDS-1:0]   r_a;
    logic [W*WORDS-1:0]   r_b;
    logic [W*WORDS-1:0]   r_sum;
    logic                 r_carry;
    logic [IW-1:0]        r_idx;
    logic                 r_cout;
    logic                 r_of;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;

    logic [W-1:0]         w_a_word;
    logic [W-1:0]         w_b_word;
    logic [W-1:0]         w_sum;
    logic                 w_cout;
    logic                 w_of;
    logic                 w_last;

    assign w_a_word = r_a[W*r_idx +: W];
    assign w_b_word = r_b[W*r_idx +: W];
    assign w_last   = (r_idx == IW'(WORDS - 1));

    adder_word #(.W(W)) u_adder (
        .a    (w_a_word),
        .b    (w_b_word),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout),
        .of   (w_of)
    );

    // Subtract is folded in at accept time: B is stored inverted and the carry seeded with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_cout      <= 1'b0;
            r_of        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.in_a;
                        r_b        <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        r_carry    <= bus.in_sub ? 1'b1 : bus.in_cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum[W*r_idx +: W] <= w_sum;
                    r_carry             <= w_cout;
                    r_idx               <= r_idx + 1'b1;
                    if (w_last) begin
                        r_idx       <= '0;
                        r_cout      <= w_cout;
                        r_of        <= w_of;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_of    = r_of;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed-vector bench for multiword_add_seq with W=32, WORDS=4.
module tb_multiword_add_seq;

    localparam int unsigned W     = 32;
    localparam int unsigned WORDS = 4;
    localparam int unsigned N     = W * WORDS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    multiword_add_seq_if #(.W(W), .WORDS(WORDS)) bus ();

    multiword_add_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request, checks it was acceptable, then scrambles the inputs.
    task automatic start_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic sub, input logic cin);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        check({tag, " in_ready"}, N'(bus.in_ready), N'(1'b1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = {4{32'hDEADBEEF}};
        bus.in_b     = {4{32'h5A5A5A5A}};
        bus.in_sub   = ~sub;
        bus.in_cin   = ~cin;
    endtask

    task automatic wait_result(input string tag, input int exp_cyc, input logic [N-1:0] exp_sum,
                               input logic exp_cout, input logic exp_of);
        int cyc;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, N'(cyc), N'(exp_cyc));
        check({tag, " sum"}, bus.out_sum, exp_sum);
        check({tag, " cout"}, N'(bus.out_cout), N'(exp_cout));
        check({tag, " of"}, N'(bus.out_of), N'(exp_of));
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " drain out_valid"}, N'(bus.out_valid), N'(1'b0));
        check({tag, " drain in_ready"}, N'(bus.in_ready), N'(1'b1));
        check({tag, " drain busy"}, N'(bus.busy), N'(1'b0));
    endtask

    initial begin
        logic [N-1:0] held;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check("reset out_valid", N'(bus.out_valid), N'(1'b0));
        check("reset in_ready", N'(bus.in_ready), N'(1'b1));
        check("reset busy", N'(bus.busy), N'(1'b0));
        check("reset sum", bus.out_sum, '0);
        check("reset cout", N'(bus.out_cout), N'(1'b0));
        check("reset of", N'(bus.out_of), N'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Carry ripple across three words
        start_op("ripple", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0);
        check("ripple busy", N'(bus.busy), N'(1'b1));
        wait_result("ripple", 4, 128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0);
        consume("ripple");

        start_op("posov", 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0);
        wait_result("posov", 4, 128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1);
        consume("posov");

        start_op("borrow", 128'h5, 128'h7, 1'b1, 1'b0);
        wait_result("borrow", 4, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0, 1'b0);
        consume("borrow");

        start_op("negov", 128'h80000000_00000000_00000000_00000000, 128'h1, 1'b1, 1'b0);
        wait_result("negov", 4, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 1'b1);
        consume("negov");

        start_op("cin", {N{1'b1}}, 128'h0, 1'b0, 1'b1);
        wait_result("cin", 4, 128'h0, 1'b1, 1'b0);
        consume("cin");

        // Backpressure with a competing request held high during DONE
        start_op("bp", 128'h10, 128'h20, 1'b0, 1'b0);
        wait_result("bp", 4, 128'h30, 1'b0, 1'b0);
        held = bus.out_sum;
        bus.in_a     = 128'h5;
        bus.in_b     = 128'h3;
        bus.in_sub   = 1'b1;
        bus.in_cin   = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp hold valid", N'(bus.out_valid), N'(1'b1));
            check("bp hold sum", bus.out_sum, held);
            check("bp hold in_ready", N'(bus.in_ready), N'(1'b0));
        end
        check("bp hold cout", N'(bus.out_cout), N'(1'b0));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp drain out_valid", N'(bus.out_valid), N'(1'b0));
        check("bp drain in_ready", N'(bus.in_ready), N'(1'b1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("b2b accepted in_ready", N'(bus.in_ready), N'(1'b0));
        check("b2b accepted busy", N'(bus.busy), N'(1'b1));
        wait_result("b2b", 4, 128'h2, 1'b1, 1'b0);
        consume("b2b");

        // Asynchronous reset two cycles into RUN
        start_op("abort", 128'h11111111_22222222_33333333_44444444, 128'h01010101_02020202_03030303_04040404,
                 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort out_valid", N'(bus.out_valid), N'(1'b0));
        check("abort sum", bus.out_sum, '0);
        check("abort in_ready", N'(bus.in_ready), N'(1'b1));
        check("abort busy", N'(bus.busy), N'(1'b0));
        check("abort cout", N'(bus.out_cout), N'(1'b0));
        check("abort of", N'(bus.out_of), N'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("abort no result", N'(bus.out_valid), N'(1'b0));
        end

        start_op("after", 128'h123, 128'h123, 1'b0, 1'b1);
        wait_result("after", 4, 128'h247, 1'b0, 1'b0);
        consume("after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
